phrase_sequencer: RTL and testbench

PHRASE_SEQUENCER -- requirements
Module: phrase_sequencer

---
 rtl/phrase_sequencer.sv | 160 ++++++++++++++++
 tb/tb_phrase_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/phrase_sequencer.sv
// rtl/phrase_sequencer.sv - writes status phrases into the text plane, one letter per ack
module phrase_sequencer #(
  parameter logic [12:0] BASE_ADDR  = 13'd3540,
  parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  stateGame,
  input  logic        frame_start,
  input  logic        letter_ack,
  output logic        letter_valid,
  output logic [7:0]  letter_ascii,
  output logic [12:0] letter_addr,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, ARMED, CLEAR, WRITE, FINISH} state_t;

  localparam logic [159:0] TXT_START = "PRESS START TO BEGIN";
  localparam logic [87:0]  TXT_PAUSE = "GAME PAUSED";
  localparam logic [71:0]  TXT_OVER  = "GAME OVER";
  localparam logic [79:0]  TXT_RESET = "GAME RESET";

  function automatic logic [4:0] phrase_len(input logic [2:0] id);
    case (id)
      3'b000:  phrase_len = 5'd20;
      3'b010:  phrase_len = 5'd11;
      3'b011:  phrase_len = 5'd9;
      3'b100:  phrase_len = 5'd10;
      default: phrase_len = 5'd0;
    endcase
  endfunction

  // Strings are packed with the first character in the top byte.
  function automatic logic [7:0] phrase_char(input logic [2:0] id, input logic [4:0] i);
    phrase_char = 8'h00;
    case (id)
      3'b000: if (i < 5'd20) phrase_char = 8'(TXT_START >> (8 * (19 - int'(i))));
      3'b010: if (i < 5'd11) phrase_char = 8'(TXT_PAUSE >> (8 * (10 - int'(i))));
      3'b011: if (i < 5'd9)  phrase_char = 8'(TXT_OVER  >> (8 * (8 - int'(i))));
      3'b100: if (i < 5'd10) phrase_char = 8'(TXT_RESET >> (8 * (9 - int'(i))));
      default: phrase_char = 8'h00;
    endcase
  endfunction

  state_t     state;
  logic [2:0] prev_game;
  logic [2:0] pend_id;
  logic [2:0] cur_id;
  logic       pending;
  logic [4:0] shown_len;
  logic [4:0] idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      letter_valid <= 1'b0;
      letter_ascii <= 8'h00;
      letter_addr  <= 13'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      shown_len    <= 5'd0;
      pending      <= 1'b0;
      idx          <= 5'd0;
      pend_id      <= 3'b000;
      cur_id       <= 3'b000;
      prev_game    <= stateGame;
    end else begin
      prev_game <= stateGame;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (pending) begin
            state   <= ARMED;
            busy    <= 1'b1;
            pending <= 1'b0;
          end
        end
        ARMED: begin
          if (frame_start) begin
            // Latch the phrase so later stateGame changes cannot disturb this pass.
            cur_id <= pend_id;
            idx    <= 5'd0;
            if (shown_len != 5'd0) begin
              state        <= CLEAR;
              letter_valid <= 1'b1;
              letter_ascii <= CLEAR_CHAR;
              letter_addr  <= BASE_ADDR;
            end else if (phrase_len(pend_id) != 5'd0) begin
              state        <= WRITE;
              letter_valid <= 1'b1;
              letter_ascii <= phrase_char(pend_id, 5'd0);
              letter_addr  <= BASE_ADDR;
            end else begin
              state <= FINISH;
              done  <= 1'b1;
            end
          end
        end
        CLEAR: begin
          if (letter_valid && letter_ack) begin
            if (idx == shown_len - 5'd1) begin
              shown_len <= 5'd0;
              idx       <= 5'd0;
              if (phrase_len(cur_id) != 5'd0) begin
                state        <= WRITE;
                letter_ascii <= phrase_char(cur_id, 5'd0);
                letter_addr  <= BASE_ADDR;
              end else begin
                state        <= FINISH;
                letter_valid <= 1'b0;
                done         <= 1'b1;
              end
            end else begin
              idx          <= idx + 5'd1;
              letter_ascii <= CLEAR_CHAR;
              letter_addr  <= BASE_ADDR + {8'd0, idx + 5'd1};
            end
          end
        end
        WRITE: begin
          if (letter_valid && letter_ack) begin
            if (idx == phrase_len(cur_id) - 5'd1) begin
              shown_len    <= phrase_len(cur_id);
              idx          <= 5'd0;
              state        <= FINISH;
              letter_valid <= 1'b0;
              done         <= 1'b1;
            end else begin
              idx          <= idx + 5'd1;
              letter_ascii <= phrase_char(cur_id, idx + 5'd1);
              letter_addr  <= BASE_ADDR + {8'd0, idx + 5'd1};
            end
          end
        end
        FINISH: begin
          if (pending) begin
            state   <= ARMED;
            pending <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          letter_valid <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
      // Placed last so a change arriving while the flag is consumed still wins.
      if (stateGame != prev_game) begin
        pend_id <= stateGame;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phrase_sequencer.sv
// tb/tb_phrase_sequencer.sv - directed vector bench for phrase_sequencer
module tb_phrase_sequencer;

  localparam logic [12:0] BASE = 13'd3540;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  sg;
  logic        fs;
  logic        ack;
  logic        letter_valid;
  logic [7:0]  letter_ascii;
  logic [12:0] letter_addr;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  phrase_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .stateGame    (sg),
    .frame_start  (fs),
    .letter_ack   (ack),
    .letter_valid (letter_valid),
    .letter_ascii (letter_ascii),
    .letter_addr  (letter_addr),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sg;
    logic        fs;
    logic        ack;
    logic        ev;
    logic [7:0]  ea;
    logic [12:0] ead;
    logic        eb;
    logic        ed;
    bit          care;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(logic [2:0] s, logic f, logic a, logic ev, logic [7:0] ea,
                              logic [12:0] ead, logic eb, logic ed, bit care);
    vec_t v;
    v.sg = s; v.fs = f; v.ack = a; v.ev = ev; v.ea = ea;
    v.ead = ead; v.eb = eb; v.ed = ed; v.care = care;
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(string tag, logic ev, logic [7:0] ea, logic [12:0] ead,
                     logic eb, logic ed, bit care);
    checks++;
    if (letter_valid !== ev || busy !== eb || done !== ed ||
        (care && (letter_ascii !== ea || letter_addr !== ead))) begin
      failures++;
      $display("FAIL %s: got v=%0b ascii=%h addr=%0d busy=%0b done=%0b, want v=%0b ascii=%h addr=%0d busy=%0b done=%0b",
               tag, letter_valid, letter_ascii, letter_addr, busy, done, ev, ea, ead, eb, ed);
    end
  endtask

  task automatic chk_letter(string tag, logic [7:0] ch, int i);
    chk($sformatf("%s[%0d]", tag, i), 1'b1, ch, BASE + 13'(i), 1'b1, 1'b0, 1'b1);
  endtask

  task automatic arm_and_go(string tag, logic [2:0] s);
    sg = s; ack = 1'b1; fs = 1'b0;
    tick();
    tick();
    chk({tag, "_armed"}, 1'b0, 8'h00, 13'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk({tag, "_wait"}, 1'b0, 8'h00, 13'd0, 1'b1, 1'b0, 1'b0);
    fs = 1'b1;
    tick();
    fs = 1'b0;
  endtask

  task automatic stream(string tag, int nclr, string ph, int stall_idx, int stall_n);
    for (int i = 0; i < nclr; i++) begin
      chk_letter({tag, "_clr"}, 8'h20, i);
      ack = 1'b1;
      tick();
    end
    for (int i = 0; i < ph.len(); i++) begin
      if (i == stall_idx) begin
        for (int s = 0; s < stall_n; s++) begin
          chk_letter({tag, "_stall"}, ph[i], i);
          ack = 1'b0;
          tick();
        end
      end
      chk_letter({tag, "_wr"}, ph[i], i);
      ack = 1'b1;
      tick();
    end
  endtask

  task automatic finish_idle(string tag);
    chk({tag, "_done"}, 1'b0, 8'h00, 13'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk({tag, "_idle"}, 1'b0, 8'h00, 13'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string start_s;
    string over_s;
    start_s = "PRESS START TO BEGIN";
    over_s  = "GAME OVER";

    vecs[0] = mk(3'b001, 1'b0, 1'b1, 1'b0, 8'h00, 13'd0, 1'b0, 1'b0, 1'b1);
    vecs[1] = mk(3'b000, 1'b0, 1'b1, 1'b0, 8'h00, 13'd0, 1'b0, 1'b0, 1'b1);
    vecs[2] = mk(3'b000, 1'b0, 1'b1, 1'b0, 8'h00, 13'd0, 1'b1, 1'b0, 1'b1);
    vecs[3] = mk(3'b000, 1'b0, 1'b1, 1'b0, 8'h00, 13'd0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++)
      vecs[4 + k] = mk(3'b000, (k == 0), 1'b1, 1'b1, start_s[k], BASE + 13'(k), 1'b1, 1'b0, 1'b1);
    vecs[24] = mk(3'b000, 1'b0, 1'b1, 1'b0, 8'h00, 13'd0, 1'b1, 1'b1, 1'b0);
    vecs[25] = mk(3'b000, 1'b0, 1'b1, 1'b0, 8'h00, 13'd0, 1'b0, 1'b0, 1'b0);

    reset = 1'b1; sg = 3'b001; fs = 1'b0; ack = 1'b1;
    tick();
    tick();
    chk("reset_state", 1'b0, 8'h00, 13'd0, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;

    for (int v = 0; v < 26; v++) begin
      sg = vecs[v].sg; fs = vecs[v].fs; ack = vecs[v].ack;
      tick();
      chk($sformatf("start_vec[%0d]", v), vecs[v].ev, vecs[v].ea, vecs[v].ead,
          vecs[v].eb, vecs[v].ed, vecs[v].care);
    end

    fs = 1'b1;
    tick();
    fs = 1'b0;
    chk("fs_ignored_idle", 1'b0, 8'h00, 13'd0, 1'b0, 1'b0, 1'b0);

    arm_and_go("over", 3'b011);
    stream("over", 20, "GAME OVER", -1, 0);
    finish_idle("over");

    arm_and_go("pause", 3'b010);
    stream("pause", 9, "GAME PAUSED", -1, 0);
    finish_idle("pause");

    arm_and_go("bp", 3'b100);
    stream("bp", 11, "GAME RESET", 5, 3);
    finish_idle("bp");

    arm_and_go("mid", 3'b000);
    for (int i = 0; i < 10; i++) begin
      chk_letter("mid_clr", 8'h20, i);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      chk_letter("mid_wr", start_s[i], i);
      if (i == 3) sg = 3'b011;
      if (i == 8) sg = 3'b010;
      tick();
    end
    chk("mid_done", 1'b0, 8'h00, 13'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("mid_rearmed", 1'b0, 8'h00, 13'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("mid_waiting", 1'b0, 8'h00, 13'd0, 1'b1, 1'b0, 1'b0);
    fs = 1'b1;
    tick();
    fs = 1'b0;
    stream("mid2", 20, "GAME PAUSED", -1, 0);
    finish_idle("mid2");

    sg = 3'b011;
    tick();
    sg = 3'b010;
    tick();
    chk("same_armed", 1'b0, 8'h00, 13'd0, 1'b1, 1'b0, 1'b0);
    fs = 1'b1;
    tick();
    fs = 1'b0;
    stream("same1", 11, "GAME PAUSED", -1, 0);
    chk("same1_done", 1'b0, 8'h00, 13'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("same_rearmed", 1'b0, 8'h00, 13'd0, 1'b1, 1'b0, 1'b0);
    fs = 1'b1;
    tick();
    fs = 1'b0;
    stream("same2", 11, "GAME PAUSED", -1, 0);
    finish_idle("same2");

    arm_and_go("blank", 3'b001);
    stream("blank", 11, "", -1, 0);
    finish_idle("blank");
    arm_and_go("none", 3'b101);
    finish_idle("none");

    arm_and_go("rst", 3'b011);
    for (int i = 0; i < 5; i++) begin
      chk_letter("rst_wr", over_s[i], i);
      tick();
    end
    chk_letter("rst_wr", over_s[5], 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_cleared", 1'b0, 8'h00, 13'd0, 1'b0, 1'b0, 1'b1);
    fs = 1'b1;
    tick();
    fs = 1'b0;
    chk("rst_fs_quiet", 1'b0, 8'h00, 13'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_quiet", 1'b0, 8'h00, 13'd0, 1'b0, 1'b0, 1'b0);
    end
    arm_and_go("post", 3'b010);
    stream("post", 0, "GAME PAUSED", -1, 0);
    finish_idle("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
